// File: rtl/mps_reg_write_arbiter.sv
// rtl/mps_reg_write_arbiter.sv - round-robin serialiser of AXI word writes and assembled DSP half-word commits onto one register-bank write port
module mps_reg_write_arbiter #(
    parameter int REG_NUM    = 24,
    parameter int IDX_WIDTH  = 5,
    parameter int XINTF_BASE = 128
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESET,
    input  logic                 i_axi_req,
    input  logic [IDX_WIDTH-1:0] i_axi_idx,
    input  logic [31:0]          i_axi_data,
    input  logic [3:0]           i_axi_strb,
    output logic                 o_axi_ack,
    input  logic [8:0]           i_xintf_addr,
    input  logic [15:0]          i_xintf_data,
    input  logic                 i_dsp_we,
    output logic                 o_wr_en,
    output logic [IDX_WIDTH-1:0] o_wr_idx,
    output logic [31:0]          o_wr_data,
    output logic                 o_wr_src,
    output logic [15:0]          o_collision_cnt,
    output logic [15:0]          o_drop_cnt
);

    localparam logic [9:0]         XBASE = 10'(XINTF_BASE);
    localparam logic [9:0]         XLAST = 10'(XINTF_BASE + 2 * REG_NUM - 1);
    localparam logic [IDX_WIDTH:0] NREG  = (IDX_WIDTH + 1)'(REG_NUM);

    typedef enum logic {ST_ARB, ST_WR} state_t;

    state_t                 state, state_next;
    logic [31:0]            shadow [REG_NUM];
    logic                   we_d;
    logic                   lo_valid;
    logic [15:0]            lo_buf;
    logic [IDX_WIDTH-1:0]   lo_idx;
    logic                   dsp_pend;
    logic [IDX_WIDTH-1:0]   pend_idx;
    logic [31:0]            pend_data;
    logic                   last_src;

    logic                   grant_axi, grant_dsp, collide;
    logic [9:0]             addr_ext, addr_off;
    logic [IDX_WIDTH-1:0]   xidx;
    logic                   dsp_evt, in_range, lo_evt, hi_evt, hi_ok;
    logic                   dsp_drop, axi_oor;
    logic [31:0]            axi_base, axi_merged;

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // A pending DSP commit loses only to an AXI request when AXI was not served last
    always_comb begin
        state_next = state;
        grant_axi  = 1'b0;
        grant_dsp  = 1'b0;
        collide    = 1'b0;
        case (state)
            ST_ARB: begin
                if (i_axi_req && dsp_pend) begin
                    collide = 1'b1;
                    if (last_src) grant_axi = 1'b1;
                    else          grant_dsp = 1'b1;
                end else if (i_axi_req) begin
                    grant_axi = 1'b1;
                end else if (dsp_pend) begin
                    grant_dsp = 1'b1;
                end
                if (grant_axi || grant_dsp) state_next = ST_WR;
            end
            ST_WR:   state_next = ST_ARB;
            default: state_next = ST_ARB;
        endcase
    end

    always_comb begin
        addr_ext = {1'b0, i_xintf_addr};
        addr_off = addr_ext - XBASE;
        xidx     = IDX_WIDTH'(addr_off[9:1]);
        in_range = (addr_ext >= XBASE) && (addr_ext <= XLAST);
        dsp_evt  = we_d && !i_dsp_we;
        lo_evt   = dsp_evt && in_range && !addr_off[0];
        hi_evt   = dsp_evt && in_range && addr_off[0];
        hi_ok    = hi_evt && lo_valid && (lo_idx == xidx);
        // Drops: stray address, orphan high half, or an ungranted commit being overwritten
        dsp_drop = (dsp_evt && !in_range) || (hi_evt && !hi_ok) || (hi_ok && dsp_pend && !grant_dsp);
        axi_oor  = ({1'b0, i_axi_idx} >= NREG);
        axi_base = axi_oor ? 32'h0 : shadow[i_axi_idx];
        for (int b = 0; b < 4; b++) begin
            axi_merged[8*b +: 8] = i_axi_strb[b] ? i_axi_data[8*b +: 8] : axi_base[8*b +: 8];
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state           <= ST_ARB;
            we_d            <= 1'b1;
            lo_valid        <= 1'b0;
            lo_buf          <= '0;
            lo_idx          <= '0;
            dsp_pend        <= 1'b0;
            pend_idx        <= '0;
            pend_data       <= '0;
            last_src        <= 1'b1;
            o_axi_ack       <= 1'b0;
            o_wr_en         <= 1'b0;
            o_wr_idx        <= '0;
            o_wr_data       <= '0;
            o_wr_src        <= 1'b0;
            o_collision_cnt <= '0;
            o_drop_cnt      <= '0;
            for (int i = 0; i < REG_NUM; i++) shadow[i] <= '0;
        end else begin
            state     <= state_next;
            we_d      <= i_dsp_we;
            o_axi_ack <= 1'b0;
            o_wr_en   <= 1'b0;

            if (o_wr_en) shadow[o_wr_idx] <= o_wr_data;

            if (grant_axi) begin
                o_axi_ack <= 1'b1;
                o_wr_en   <= !axi_oor;
                o_wr_idx  <= i_axi_idx;
                o_wr_src  <= 1'b0;
                last_src  <= 1'b0;
                if (!axi_oor) o_wr_data <= axi_merged;
            end
            if (grant_dsp) begin
                o_wr_en   <= 1'b1;
                o_wr_idx  <= pend_idx;
                o_wr_data <= pend_data;
                o_wr_src  <= 1'b1;
                last_src  <= 1'b1;
                dsp_pend  <= 1'b0;
            end

            if (lo_evt) begin
                lo_buf   <= i_xintf_data;
                lo_idx   <= xidx;
                lo_valid <= 1'b1;
            end
            if (hi_evt) lo_valid <= 1'b0;
            if (hi_ok) begin
                dsp_pend  <= 1'b1;
                pend_idx  <= xidx;
                pend_data <= {i_xintf_data, lo_buf};
            end

            if (collide) o_collision_cnt <= sat_add(o_collision_cnt, 2'd1);
            o_drop_cnt <= sat_add(o_drop_cnt, {1'b0, dsp_drop} + {1'b0, grant_axi && axi_oor});
        end
    end

endmodule

// File: tb/tb_mps_reg_write_arbiter.sv
// tb/tb_mps_reg_write_arbiter.sv - randomized self-checking bench for mps_reg_write_arbiter against a transaction-level model
module tb_mps_reg_write_arbiter;

    localparam int NREG  = 24;
    localparam int XBASE = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_axi_req;
    logic [4:0]  i_axi_idx;
    logic [31:0] i_axi_data;
    logic [3:0]  i_axi_strb;
    logic        o_axi_ack;
    logic [8:0]  i_xintf_addr;
    logic [15:0] i_xintf_data;
    logic        i_dsp_we;
    logic        o_wr_en;
    logic [4:0]  o_wr_idx;
    logic [31:0] o_wr_data;
    logic        o_wr_src;
    logic [15:0] o_collision_cnt;
    logic [15:0] o_drop_cnt;

    mps_reg_write_arbiter dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESET    (rst),
        .i_axi_req       (i_axi_req),
        .i_axi_idx       (i_axi_idx),
        .i_axi_data      (i_axi_data),
        .i_axi_strb      (i_axi_strb),
        .o_axi_ack       (o_axi_ack),
        .i_xintf_addr    (i_xintf_addr),
        .i_xintf_data    (i_xintf_data),
        .i_dsp_we        (i_dsp_we),
        .o_wr_en         (o_wr_en),
        .o_wr_idx        (o_wr_idx),
        .o_wr_data       (o_wr_data),
        .o_wr_src        (o_wr_src),
        .o_collision_cnt (o_collision_cnt),
        .o_drop_cnt      (o_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        src;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_wr_seen = 0;
    bit   mon_en = 1'b1;
    exp_t exp_q[$];

    // Transaction-level model state
    logic [31:0] m_shadow [NREG];
    int          m_drop, m_coll;
    bit          m_last_dsp;
    bit          m_lo_v;
    int          m_lo_i;
    logic [15:0] m_lo_d;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_shadow[i] = '0;
        m_drop = 0; m_coll = 0; m_last_dsp = 1'b1; m_lo_v = 1'b0; m_lo_i = 0; m_lo_d = '0;
        exp_q.delete();
    endtask

    task automatic model_axi(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             output exp_t e, output bit v);
        logic [31:0] m;
        e = '{idx: 5'd0, data: 32'd0, src: 1'b0};
        v = 1'b0;
        m_last_dsp = 1'b0;
        if (idx >= NREG) begin
            m_drop++;
        end else begin
            for (int b = 0; b < 4; b++) m[8*b +: 8] = strb[b] ? data[8*b +: 8] : m_shadow[idx][8*b +: 8];
            m_shadow[idx] = m;
            e = '{idx: 5'(idx), data: m, src: 1'b0};
            v = 1'b1;
        end
    endtask

    task automatic model_dsp(input int addr, input logic [15:0] data, output exp_t e, output bit v);
        int off, idx;
        e = '{idx: 5'd0, data: 32'd0, src: 1'b0};
        v = 1'b0;
        if (addr < XBASE || addr > XBASE + 2*NREG - 1) begin
            m_drop++;
        end else begin
            off = addr - XBASE;
            idx = off / 2;
            if (off % 2 == 0) begin
                m_lo_v = 1'b1; m_lo_i = idx; m_lo_d = data;
            end else begin
                if (m_lo_v && m_lo_i == idx) begin
                    e = '{idx: 5'(idx), data: {data, m_lo_d}, src: 1'b1};
                    m_shadow[idx] = {data, m_lo_d};
                    m_last_dsp = 1'b1;
                    v = 1'b1;
                end else begin
                    m_drop++;
                end
                m_lo_v = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && o_wr_en) begin
            n_wr_seen++;
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", {31'b0, o_wr_en}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_idx", {27'b0, o_wr_idx}, {27'b0, e.idx});
                check_eq("wr_data", o_wr_data, e.data);
                check_eq("wr_src", {31'b0, o_wr_src}, {31'b0, e.src});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one AXI request from posedge+1 until acked; ends at posedge+1
    task automatic axi_drive(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             input bit exp_en, input int exp_lat);
        int lat;
        bit got;
        i_axi_req = 1'b1; i_axi_idx = 5'(idx); i_axi_data = data; i_axi_strb = strb;
        lat = 0; got = 1'b0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            if (o_axi_ack) got = 1'b1;
        end
        check_eq("axi_ack_seen", {31'b0, got}, 32'd1);
        if (got) begin
            check_eq("ack_with_wr_en", {31'b0, o_wr_en}, {31'b0, exp_en});
            if (exp_lat != 0) check_eq("axi_latency", lat, exp_lat);
        end
        @(posedge clk); #1;
        i_axi_req = 1'b0;
        @(negedge clk);
        check_eq("ack_single_pulse", {31'b0, o_axi_ack}, 32'd0);
        tick();
    endtask

    task automatic dsp_drive(input int addr, input logic [15:0] data, input int low_cycles);
        i_xintf_addr = 9'(addr); i_xintf_data = data; i_dsp_we = 1'b0;
        repeat (low_cycles) tick();
        i_dsp_we = 1'b1;
        repeat (2) tick();
    endtask

    task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb, input int exp_lat);
        exp_t e;
        bit v;
        model_axi(idx, data, strb, e, v);
        if (v) exp_q.push_back(e);
        axi_drive(idx, data, strb, v, exp_lat);
    endtask

    task automatic dsp_write(input int addr, input logic [15:0] data, input int low_cycles);
        exp_t e;
        bit v;
        model_dsp(addr, data, e, v);
        if (v) exp_q.push_back(e);
        dsp_drive(addr, data, low_cycles);
    endtask

    // Low half already buffered; high half and AXI request become visible to the arbiter together
    task automatic collision(input int axi_idx, input logic [31:0] axi_data, input int hi_addr, input logic [15:0] hi_data);
        exp_t ea, ed;
        bit va, vd;
        m_coll++;
        if (m_last_dsp) begin
            model_axi(axi_idx, axi_data, 4'hF, ea, va);
            model_dsp(hi_addr, hi_data, ed, vd);
            exp_q.push_back(ea); exp_q.push_back(ed);
        end else begin
            model_dsp(hi_addr, hi_data, ed, vd);
            model_axi(axi_idx, axi_data, 4'hF, ea, va);
            exp_q.push_back(ed); exp_q.push_back(ea);
        end
        fork
            dsp_drive(hi_addr, hi_data, 3);
            begin
                tick();
                axi_drive(axi_idx, axi_data, 4'hF, 1'b1, 0);
            end
        join
        repeat (3) tick();
    endtask

    int w0;

    initial begin
        rst = 1'b1; i_axi_req = 1'b0; i_axi_idx = '0; i_axi_data = '0; i_axi_strb = '0;
        i_xintf_addr = '0; i_xintf_data = '0; i_dsp_we = 1'b1;
        model_reset();
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_wr_en", {31'b0, o_wr_en}, 32'd0);
        check_eq("rst_ack", {31'b0, o_axi_ack}, 32'd0);
        check_eq("rst_wr_data", o_wr_data, 32'd0);
        check_eq("rst_wr_idx", {27'b0, o_wr_idx}, 32'd0);
        check_eq("rst_coll", {16'b0, o_collision_cnt}, 32'd0);
        check_eq("rst_drop", {16'b0, o_drop_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        axi_write(3, 32'h12345678, 4'hF, 2);
        axi_write(3, 32'hAABBCCDD, 4'h2, 2);
        check_eq("shadow_merge_model", m_shadow[3], 32'h1234CC78);

        w0 = n_wr_seen;
        dsp_write(134, 16'h5678, 3);
        repeat (2) tick();
        check_eq("no_wr_after_low_half", n_wr_seen - w0, 0);
        dsp_write(135, 16'h1234, 3);
        repeat (2) tick();
        check_eq("dsp_pair_one_write", n_wr_seen - w0, 1);

        w0 = n_wr_seen;
        dsp_write(137, 16'hBEEF, 3);
        dsp_write(200, 16'hDEAD, 3);
        repeat (2) tick();
        check_eq("orphan_no_write", n_wr_seen - w0, 0);
        check_eq("drop_cnt_2", {16'b0, o_drop_cnt}, 32'd2);

        dsp_write(130, 16'h1111, 2);
        collision(0, 32'hA0A0A0A0, 131, 16'h2222);
        check_eq("coll_cnt_1", {16'b0, o_collision_cnt}, 32'd1);
        axi_write(7, 32'h0F0F0F0F, 4'hF, 2);
        dsp_write(130, 16'h3333, 2);
        collision(0, 32'hB0B0B0B0, 131, 16'h4444);
        check_eq("coll_cnt_2", {16'b0, o_collision_cnt}, 32'd2);

        for (int n = 0; n < 60; n++) begin
            int op, idx;
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                axi_write($urandom_range(0, 31), $urandom, 4'($urandom_range(0, 15)), 0);
            end else if (op == 2) begin
                idx = $urandom_range(0, NREG - 1);
                dsp_write(XBASE + 2*idx, 16'($urandom), $urandom_range(1, 3));
                dsp_write(XBASE + 2*idx + 1, 16'($urandom), $urandom_range(1, 3));
            end else begin
                dsp_write($urandom_range(100, 200), 16'($urandom), $urandom_range(1, 3));
            end
        end
        repeat (3) tick();
        check_eq("rand_drop_cnt", {16'b0, o_drop_cnt}, 32'(m_drop));
        check_eq("rand_coll_cnt", {16'b0, o_collision_cnt}, 32'(m_coll));
        check_eq("rand_queue_empty", exp_q.size(), 0);

        i_axi_req = 1'b1; i_axi_idx = 5'd5; i_axi_data = 32'hCAFEF00D; i_axi_strb = 4'h3;
        mon_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_eq("rstmid_wr_en", {31'b0, o_wr_en}, 32'd0);
        check_eq("rstmid_ack", {31'b0, o_axi_ack}, 32'd0);
        check_eq("rstmid_wr_data", o_wr_data, 32'd0);
        check_eq("rstmid_drop", {16'b0, o_drop_cnt}, 32'd0);
        check_eq("rstmid_coll", {16'b0, o_collision_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        axi_write(5, 32'hCAFEF00D, 4'h3, 2);
        repeat (2) tick();
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
